// File: rtl/xunit_sha2_rounds.sv
// SHA-2 compression unit (SHA-256 at DATA_W=32, SHA-512 at DATA_W=64) with optional digest feed-forward.
// Latency delay0+ROUNDS+feed_fwd cycles after run; W_t/K_t are consumed one per round with no backpressure.
module xunit_sha2_rounds #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 32,
  parameter int ROUNDS  = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  output logic               done,
  input  logic [DATA_W-1:0]  in0,
  input  logic [DATA_W-1:0]  in1,
  input  logic [DATA_W-1:0]  in2,
  input  logic [DATA_W-1:0]  in3,
  input  logic [DATA_W-1:0]  in4,
  input  logic [DATA_W-1:0]  in5,
  input  logic [DATA_W-1:0]  in6,
  input  logic [DATA_W-1:0]  in7,
  input  logic [DATA_W-1:0]  in8,
  input  logic [DATA_W-1:0]  in9,
  output logic [DATA_W-1:0]  out0,
  output logic [DATA_W-1:0]  out1,
  output logic [DATA_W-1:0]  out2,
  output logic [DATA_W-1:0]  out3,
  output logic [DATA_W-1:0]  out4,
  output logic [DATA_W-1:0]  out5,
  output logic [DATA_W-1:0]  out6,
  output logic [DATA_W-1:0]  out7,
  input  logic [DELAY_W-1:0] delay0,
  input  logic               feed_fwd
);

  localparam int RCNT_W = $clog2(ROUNDS);
  localparam logic [RCNT_W-1:0] LAST = RCNT_W'(ROUNDS - 1);
  localparam int S0_A = (DATA_W == 64) ? 28 : 2;
  localparam int S0_B = (DATA_W == 64) ? 34 : 13;
  localparam int S0_C = (DATA_W == 64) ? 39 : 22;
  localparam int S1_A = (DATA_W == 64) ? 14 : 6;
  localparam int S1_B = (DATA_W == 64) ? 18 : 11;
  localparam int S1_C = (DATA_W == 64) ? 41 : 25;

  typedef logic [DATA_W-1:0] word_t;
  typedef enum logic [1:0] {IDLE, DELAY, ROUND, FINAL} state_t;

  state_t             state, state_nxt;
  logic [DELAY_W-1:0] cnt, cnt_nxt;
  logic [RCNT_W-1:0]  rcnt, rcnt_nxt;
  logic               do_round, use_in, do_ff;

  word_t in_w [8];
  word_t wv   [8];
  word_t hs   [8];
  word_t src  [8];
  word_t sig0, sig1, ch, maj, t1, t2;

  function automatic word_t rotr(input word_t x, input int n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  assign in_w = '{in0, in1, in2, in3, in4, in5, in6, in7};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      rcnt  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rcnt  <= rcnt_nxt;
    end
  end

  // run restarts from any state and suppresses the round/add of the current cycle
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rcnt_nxt  = rcnt;
    do_round  = 1'b0;
    use_in    = 1'b0;
    do_ff     = 1'b0;
    if (run) begin
      state_nxt = DELAY;
      cnt_nxt   = delay0;
      rcnt_nxt  = '0;
    end else begin
      case (state)
        DELAY: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - DELAY_W'(1);
          end else begin
            do_round  = 1'b1;
            use_in    = 1'b1;
            rcnt_nxt  = RCNT_W'(1);
            state_nxt = ROUND;
          end
        end
        ROUND: begin
          do_round = 1'b1;
          rcnt_nxt = rcnt + RCNT_W'(1);
          if (rcnt == LAST) state_nxt = feed_fwd ? FINAL : IDLE;
        end
        FINAL: begin
          do_ff     = 1'b1;
          state_nxt = IDLE;
        end
        default: ;
      endcase
    end
  end

  // Round 0 works directly on the hash inputs so no load cycle is needed
  always_comb begin
    for (int i = 0; i < 8; i++) src[i] = use_in ? in_w[i] : wv[i];
    sig0 = rotr(src[0], S0_A) ^ rotr(src[0], S0_B) ^ rotr(src[0], S0_C);
    sig1 = rotr(src[4], S1_A) ^ rotr(src[4], S1_B) ^ rotr(src[4], S1_C);
    ch   = (src[4] & src[5]) ^ (~src[4] & src[6]);
    maj  = (src[0] & src[1]) ^ (src[0] & src[2]) ^ (src[1] & src[2]);
    t1   = src[7] + sig1 + ch + in9 + in8;
    t2   = sig0 + maj;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        wv[i] <= '0;
        hs[i] <= '0;
      end
    end else if (do_round) begin
      wv[0] <= t1 + t2;
      wv[1] <= src[0];
      wv[2] <= src[1];
      wv[3] <= src[2];
      wv[4] <= src[3] + t1;
      wv[5] <= src[4];
      wv[6] <= src[5];
      wv[7] <= src[6];
      if (use_in) begin
        for (int i = 0; i < 8; i++) hs[i] <= in_w[i];
      end
    end else if (do_ff) begin
      for (int i = 0; i < 8; i++) wv[i] <= wv[i] + hs[i];
    end
  end

  assign done = (state == IDLE);
  assign out0 = wv[0];
  assign out1 = wv[1];
  assign out2 = wv[2];
  assign out3 = wv[3];
  assign out4 = wv[4];
  assign out5 = wv[5];
  assign out6 = wv[6];
  assign out7 = wv[7];

endmodule

// File: tb/tb_xunit_sha2_rounds.sv
// Bench for xunit_sha2_rounds: SHA-256 and SHA-512 instances, expected digests queued at issue and checked on done.
`timescale 1ns/1ps
module tb_xunit_sha2_rounds;

  localparam logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam logic [63:0] K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

  typedef struct packed {
    logic [7:0][63:0] o;
    int               lat;
    bit               chk;
    int               tag;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [63:0] hin   [2][8];
  logic [63:0] w_in  [2];
  logic [63:0] k_in  [2];
  logic        run_r [2];
  logic [31:0] dly   [2];
  logic        ff    [2];
  logic        dn    [2];
  logic [31:0] o32   [8];
  logic [63:0] o64   [8];
  logic [63:0] outs  [2][8];

  exp_t sb0[$];
  exp_t sb1[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      outs[0][i] = {32'b0, o32[i]};
      outs[1][i] = o64[i];
    end
  end

  xunit_sha2_rounds #(.DATA_W(32), .DELAY_W(32), .ROUNDS(64)) dut256 (
    .clk(clk), .rst_n(rst_n), .run(run_r[0]), .done(dn[0]),
    .in0(hin[0][0][31:0]), .in1(hin[0][1][31:0]), .in2(hin[0][2][31:0]), .in3(hin[0][3][31:0]),
    .in4(hin[0][4][31:0]), .in5(hin[0][5][31:0]), .in6(hin[0][6][31:0]), .in7(hin[0][7][31:0]),
    .in8(w_in[0][31:0]), .in9(k_in[0][31:0]),
    .out0(o32[0]), .out1(o32[1]), .out2(o32[2]), .out3(o32[3]),
    .out4(o32[4]), .out5(o32[5]), .out6(o32[6]), .out7(o32[7]),
    .delay0(dly[0]), .feed_fwd(ff[0]));

  xunit_sha2_rounds #(.DATA_W(64), .DELAY_W(32), .ROUNDS(80)) dut512 (
    .clk(clk), .rst_n(rst_n), .run(run_r[1]), .done(dn[1]),
    .in0(hin[1][0]), .in1(hin[1][1]), .in2(hin[1][2]), .in3(hin[1][3]),
    .in4(hin[1][4]), .in5(hin[1][5]), .in6(hin[1][6]), .in7(hin[1][7]),
    .in8(w_in[1]), .in9(k_in[1]),
    .out0(o64[0]), .out1(o64[1]), .out2(o64[2]), .out3(o64[3]),
    .out4(o64[4]), .out5(o64[5]), .out6(o64[6]), .out7(o64[7]),
    .delay0(dly[1]), .feed_fwd(ff[1]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [31:0] r32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] r64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Message schedule expansion; W_t for SHA-256 is kept in the low 32 bits
  function automatic void sched(input bit is512, input logic [63:0] m [16], output logic [63:0] w [80]);
    logic [31:0] a, b;
    logic [63:0] x, y;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 80; t++) begin
      if (!is512) begin
        a = r32(w[t-15][31:0], 7) ^ r32(w[t-15][31:0], 18) ^ (w[t-15][31:0] >> 3);
        b = r32(w[t-2][31:0], 17) ^ r32(w[t-2][31:0], 19) ^ (w[t-2][31:0] >> 10);
        w[t] = {32'b0, w[t-16][31:0] + a + w[t-7][31:0] + b};
      end else begin
        x = r64(w[t-15], 1) ^ r64(w[t-15], 8) ^ (w[t-15] >> 7);
        y = r64(w[t-2], 19) ^ r64(w[t-2], 61) ^ (w[t-2] >> 6);
        w[t] = w[t-16] + x + w[t-7] + y;
      end
    end
  endfunction

  // Issues one block; abort_at >= 0 stops streaming before that round and queues nothing
  task automatic run_block(input int id, input logic [63:0] h [8], input logic [63:0] w [80],
                           input int d, input bit f, input int abort_at, input bit chain,
                           input bit chk_out, input logic [63:0] ex [8], input int tag);
    exp_t e;
    int   nr;
    nr = (id == 0) ? 64 : 80;
    @(negedge clk);
    for (int i = 0; i < 8; i++) hin[id][i] = chain ? outs[id][i] : h[i];
    dly[id]   = d;
    ff[id]    = f;
    run_r[id] = 1'b1;
    if (abort_at < 0) begin
      for (int i = 0; i < 8; i++) e.o[i] = ex[i];
      e.lat = d + nr + int'(f);
      e.chk = chk_out;
      e.tag = tag;
      if (id == 0) sb0.push_back(e);
      else sb1.push_back(e);
    end
    @(negedge clk);
    run_r[id] = 1'b0;
    repeat (d) @(negedge clk);
    for (int t = 0; t < nr; t++) begin
      if (t == abort_at) return;
      w_in[id] = w[t];
      k_in[id] = (id == 0) ? {32'b0, K256[t]} : K512[t];
      @(negedge clk);
    end
    if (f) @(negedge clk);
  endtask

  // Counts done-low cycles since the latest run and checks the queued result on each rising done
  task automatic monitor(input int id);
    int   low_cnt;
    bit   prev;
    bit   rs;
    bit   empty;
    exp_t e;
    low_cnt = 0;
    prev    = 1'b1;
    forever begin
      @(posedge clk);
      rs = run_r[id];
      @(negedge clk);
      if (rs) low_cnt = 0;
      if (!rst_n) begin
        prev    = 1'b1;
        low_cnt = 0;
      end else begin
        if (!dn[id]) begin
          low_cnt++;
        end else if (!prev) begin
          empty = (id == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
          if (empty) begin
            n_tot++;
            $display("FAIL dut%0d unexpected done: got done=1 after %0d cycles, required no completion", id, low_cnt);
          end else begin
            e = (id == 0) ? sb0.pop_front() : sb1.pop_front();
            chk($sformatf("blk%0d latency", e.tag), 64'(low_cnt), 64'(e.lat));
            if (e.chk) begin
              for (int i = 0; i < 8; i++)
                chk($sformatf("blk%0d out%0d", e.tag, i), outs[id][i], e.o[i]);
            end
          end
        end
        prev = dn[id];
      end
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
    join_none
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [63:0] iv256 [8], iv512 [8], dig_abc [8], dig512 [8], dig2 [8], ex_noff [8], zero8 [8];
  logic [63:0] m [16];
  logic [63:0] w_abc [80], w_512 [80], w_b1 [80], w_b2 [80];
  logic [7:0]  bt;

  initial begin
    rst_n = 1'b0;
    for (int j = 0; j < 2; j++) begin
      run_r[j] = 1'b0; dly[j] = '0; ff[j] = 1'b0; w_in[j] = '0; k_in[j] = '0;
      for (int i = 0; i < 8; i++) hin[j][i] = '0;
    end
    iv256   = '{64'h6a09e667, 64'hbb67ae85, 64'h3c6ef372, 64'ha54ff53a,
                64'h510e527f, 64'h9b05688c, 64'h1f83d9ab, 64'h5be0cd19};
    iv512   = '{64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
                64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    dig_abc = '{64'hba7816bf, 64'h8f01cfea, 64'h414140de, 64'h5dae2223,
                64'hb00361a3, 64'h96177a9c, 64'hb410ff61, 64'hf20015ad};
    dig512  = '{64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
                64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};
    dig2    = '{64'h248d6a61, 64'hd20638b8, 64'he5c02693, 64'h0c3e6039,
                64'ha33ce459, 64'h64ff2167, 64'hf6ecedd4, 64'h19db06c1};
    for (int i = 0; i < 8; i++) begin
      zero8[i]   = '0;
      ex_noff[i] = {32'b0, dig_abc[i][31:0] - iv256[i][31:0]};
    end

    for (int i = 0; i < 16; i++) m[i] = '0;
    m[0] = 64'h61626380; m[15] = 64'h18;
    sched(1'b0, m, w_abc);
    m[0] = 64'h6162638000000000;
    sched(1'b1, m, w_512);
    for (int i = 0; i < 14; i++) begin
      bt   = 8'h61 + 8'(i);
      m[i] = {32'b0, bt, bt + 8'd1, bt + 8'd2, bt + 8'd3};
    end
    m[14] = 64'h80000000; m[15] = '0;
    sched(1'b0, m, w_b1);
    for (int i = 0; i < 16; i++) m[i] = '0;
    m[15] = 64'h1c0;
    sched(1'b0, m, w_b2);

    repeat (3) @(negedge clk);
    chk("reset done256", 64'(dn[0]), 64'd1);
    chk("reset done512", 64'(dn[1]), 64'd1);
    chk("reset out0", outs[0][0], 64'd0);
    chk("reset out7_512", outs[1][7], 64'd0);
    #2 rst_n = 1'b1;

    run_block(0, iv256, w_abc, 0, 1'b1, -1, 1'b0, 1'b1, dig_abc, 1);
    run_block(1, iv512, w_512, 0, 1'b1, -1, 1'b0, 1'b1, dig512, 2);
    run_block(0, iv256, w_abc, 3, 1'b0, -1, 1'b0, 1'b1, ex_noff, 3);
    run_block(0, iv256, w_abc, 0, 1'b1, 20, 1'b0, 1'b0, zero8, 0);
    run_block(0, iv256, w_abc, 0, 1'b1, -1, 1'b0, 1'b1, dig_abc, 4);
    run_block(0, iv256, w_b1, 0, 1'b1, -1, 1'b0, 1'b0, zero8, 5);
    run_block(0, iv256, w_b2, 0, 1'b1, -1, 1'b1, 1'b1, dig2, 6);

    run_block(0, iv256, w_abc, 0, 1'b1, 10, 1'b0, 1'b0, zero8, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midblock reset done", 64'(dn[0]), 64'd1);
    for (int i = 0; i < 8; i++) chk($sformatf("midblock reset out%0d", i), outs[0][i], 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("post reset done", 64'(dn[0]), 64'd1);
    chk("post reset out0", outs[0][0], 64'd0);
    chk("post reset out4", outs[0][4], 64'd0);

    for (int i = 0; i < 200 && (sb0.size() != 0 || sb1.size() != 0); i++) @(negedge clk);
    if (sb0.size() != 0 || sb1.size() != 0) begin
      n_tot++;
      $display("FAIL drain: got %0d pending results, required 0", sb0.size() + sb1.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
